// File: rtl/program_memory_loader_if.sv
// Program memory / loader bus.
// Carries the fetch path from the program sequencer (pm_addr -> pm_data)
// and the byte-serial load port (load_start/load_valid/load_data/load_ready)
// together with the loader status outputs (load_done, load_err, hold_cpu).
//   master : drives pm_addr and the load_* inputs, observes the rest
//   slave  : the program memory loader itself
interface program_memory_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] pm_addr;
    logic [DATA_W-1:0] pm_data;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic              load_err;
    logic              hold_cpu;

    modport master (
        output pm_addr, load_start, load_valid, load_data,
        input  pm_data, load_ready, load_done, load_err, hold_cpu
    );

    modport slave (
        input  pm_addr, load_start, load_valid, load_data,
        output pm_data, load_ready, load_done, load_err, hold_cpu
    );
endinterface

// File: rtl/program_memory_loader.sv
// Program memory with a run-time byte-serial loader.
// Fetch: pm_data is the registered byte at pm_addr (1-cycle latency), forced
// to zero while the CPU is held.
// Load: after load_start, the loader accepts a length header (00 = 256),
// N program bytes written to addresses 0..N-1, and a checksum byte. The CPU
// is released (hold_cpu=0, load_done=1) only when sum(bytes)+checksum == 0
// mod 256; otherwise load_err is raised and the CPU stays held.
// Ports:
//   clk        : system clock
//   sync_reset : synchronous active-high reset
//   bus        : program_memory_loader_if slave (fetch + load + status)
module program_memory_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input logic                    clk,
    input logic                    sync_reset,
    program_memory_loader_if.slave bus
);

    typedef enum logic [2:0] {IDLE, HEADER, LOAD, CHECK, RUN, ERROR} state_t;

    // Length and counter are one bit wider than the address so that a
    // header of 00 (256 bytes) is representable and the count never wraps.
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   len_hdr;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] pm_data_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              clr;
    logic              len_ld;
    logic              wr_en;
    logic              sum_ok;

    function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    assign bus.load_ready = (state == HEADER) || (state == LOAD) || (state == CHECK);
    assign bus.hold_cpu   = (state != RUN);
    assign bus.load_done  = (state == RUN);
    assign bus.load_err   = (state == ERROR);
    assign bus.pm_data    = pm_data_q;

    assign accept  = bus.load_valid && bus.load_ready;
    assign len_hdr = (bus.load_data == '0) ? LEN_MAX
                                           : {{(ADDR_W+1-DATA_W){1'b0}}, bus.load_data};
    assign sum_ok  = (add_mod(sum, bus.load_data) == '0);

    // Next-state and datapath controls; load_start overrides any byte.
    always_comb begin
        next_state = state;
        clr        = 1'b0;
        len_ld     = 1'b0;
        wr_en      = 1'b0;
        if (bus.load_start) begin
            next_state = HEADER;
            clr        = 1'b1;
        end else begin
            unique case (state)
                HEADER: if (accept) begin
                    len_ld     = 1'b1;
                    next_state = LOAD;
                end
                LOAD: if (accept) begin
                    wr_en = 1'b1;
                    if (cnt == len - ONE) next_state = CHECK;
                end
                CHECK: if (accept) next_state = sum_ok ? RUN : ERROR;
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            sum   <= '0;
        end else begin
            state <= next_state;
            if (clr) begin
                cnt <= '0;
                sum <= '0;
            end
            if (len_ld) len <= len_hdr;
            if (wr_en) begin
                cnt <= cnt + ONE;
                sum <= add_mod(sum, bus.load_data);
            end
        end
    end

    // Memory array is deliberately not reset; loaded programs survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && !sync_reset) mem[cnt[ADDR_W-1:0]] <= bus.load_data;
    end

    // Fetch register. Writes only happen while held, so no read/write overlap.
    always_ff @(posedge clk) begin
        if (sync_reset) pm_data_q <= '0;
        else            pm_data_q <= bus.hold_cpu ? '0 : mem[bus.pm_addr];
    end

endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
Program memory for the microprocessor, sitting directly downstream of the program sequencer: consumes its 8-bit pm_addr and returns the instruction byte one clock later.
Adds a byte-serial load port with valid/ready handshake, length header and checksum, so programs can be written into RAM at run time.
Holds the processor in reset (hold_cpu drives the sequencer's sync_reset) until a load completes with a good checksum.

Parameters:
ADDR_W, 8, program address width (matches sequencer pm_addr)
DATA_W, 8, instruction/load byte width
DEPTH, 256, memory words (2**ADDR_W)

Ports:
clk  input  1  system clock, all state updates on posedge
sync_reset  input  1  synchronous, active-high reset
pm_addr  input  ADDR_W  fetch address from program sequencer
pm_data  output  DATA_W  registered instruction byte
load_start  input  1  one-cycle pulse: begin a new load session
load_valid  input  1  load_data holds a valid byte
load_data  input  DATA_W  header, program or checksum byte
load_ready  output  1  loader accepts a byte this cycle
load_done  output  1  level: last load passed checksum, CPU running
load_err  output  1  level: last load failed checksum
hold_cpu  output  1  high = keep sequencer in reset

Behaviour:
- Clock and reset: one clock (clk); reset is sync_reset, synchronous and active-high.
- Reset values: state=IDLE, pm_data=8'h00, load_ready=0, load_done=0, load_err=0, hold_cpu=1, byte counter=0, length=0, running sum=0.
- Memory contents are not cleared by reset.
- States: IDLE, HEADER, LOAD, CHECK, RUN, ERROR.
- Accept: a byte is accepted on the posedge where load_valid && load_ready.
- load_ready: 1 exactly in HEADER, LOAD, CHECK (registered; follows state).
- IDLE / RUN / ERROR: load_start -> HEADER; the counter and sum are cleared.
- HEADER: an accepted byte sets length N. 8'h00 means 256. Go to LOAD.
- LOAD: each accepted byte is written to mem[cnt] at that edge; cnt++ and sum += byte (mod 256). When the byte written is at cnt == N-1, go to CHECK.
- CHECK: an accepted byte C is compared. If (sum + C) mod 256 == 0, go to RUN; else go to ERROR.
- Addresses >= N are left untouched by a load.
- load_start while in HEADER/LOAD/CHECK: restarts at HEADER, clears the counter and sum, and keeps the partial writes.
- load_start and an accepted byte in the same cycle: load_start wins and the byte is dropped.
- hold_cpu = 0 only in RUN. It is 1 in every other state, including the cycle after load_start in RUN.
- load_done = 1 only in RUN. load_err = 1 only in ERROR. Both clear on load_start.
- Read path: each posedge, pm_data <= hold_cpu ? 8'h00 : mem[pm_addr]. Latency is exactly 1 cycle; this is sequencer pc timing. There is no write/read collision because writes occur only while held.
- Counter width is ADDR_W+1 so that N=256 terminates correctly. The counter never wraps within a load.
- sync_reset mid-load: returns to IDLE with hold_cpu=1. Bytes already written are kept. load_done and load_err are cleared.

Test Plan:
- Reset -> hold_cpu=1, load_ready=0, pm_data=00, load_done=0, load_err=0; state stays IDLE with no load_start.
- Load N=3: load_start, then bytes 03,10,20,30,A0 (sum 60, 60+A0=00) -> done=1, hold=0. pm_addr=01 gives pm_data=20 next cycle; pm_addr=02 gives 30.
- Same session but checksum A1 -> load_err=1, hold_cpu=1, pm_data stays 00. A new load_start clears err and load_ready rises the following cycle.
- Handshake: load_valid toggles 1/0 with gaps during LOAD -> only valid cycles are written, and the addresses are contiguous 0..N-1.
- Header 00: load 256 bytes where byte i = i, then the correct checksum 80 -> RUN. Read mem[FF]=FF; the counter does not wrap early.
- Mid-load restart: load_start is asserted with load_valid after 2 of 4 bytes -> that byte is dropped and the state is HEADER. A subsequent full load of N=1 succeeds; mem[1] still holds the earlier partial byte. A sync_reset mid-load returns to IDLE with hold_cpu=1.
